// File: rtl/window_extrema_tracker.sv
// window_extrema_tracker
// Tracks min, max and rising-step count over fixed windows of WINDOW unsigned
// samples, presenting each completed window's results on a valid/ready output.
// Optional feature macro: WINDOW_INDEX_EN adds min_idx/max_idx tracking ports.
module window_extrema_tracker #(
  parameter int DATA_WIDTH = 8,
  parameter int WINDOW     = 16,
  localparam int CNT_WIDTH = $clog2(WINDOW + 1),
  localparam int IDX_WIDTH = $clog2(WINDOW)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] min_out,
  output logic [DATA_WIDTH-1:0] max_out,
`ifdef WINDOW_INDEX_EN
  output logic [IDX_WIDTH-1:0]  min_idx,
  output logic [IDX_WIDTH-1:0]  max_idx,
`endif
  output logic [CNT_WIDTH-1:0]  rise_count
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [IDX_WIDTH-1:0] LAST_POS = IDX_WIDTH'(WINDOW - 1);

  state_t state_reg, state_next;

  logic [DATA_WIDTH-1:0] run_min_reg, run_max_reg, prev_reg;
  logic [CNT_WIDTH-1:0]  run_rise_reg;
  logic [IDX_WIDTH-1:0]  cnt_reg;

  logic [DATA_WIDTH-1:0] run_min_next, run_max_next;
  logic [CNT_WIDTH-1:0]  run_rise_next;
  logic                  accept, first, last, lt_min, gt_max, gt_prev;

`ifdef WINDOW_INDEX_EN
  logic [IDX_WIDTH-1:0]  min_idx_reg, max_idx_reg;
  logic [IDX_WIDTH-1:0]  min_idx_next, max_idx_next;
`endif

  assign accept  = in_valid && (state_reg == ACCUM);
  assign first   = (cnt_reg == '0);
  assign last    = (cnt_reg == LAST_POS);
  // Strict compares: ties leave min/max (and their indices) untouched.
  assign lt_min  = in_data < run_min_reg;
  assign gt_max  = in_data > run_max_reg;
  assign gt_prev = in_data > prev_reg;

  // Running values including the sample currently offered.
  always_comb begin
    run_min_next  = run_min_reg;
    run_max_next  = run_max_reg;
    run_rise_next = run_rise_reg;
    if (first) begin
      run_min_next  = in_data;
      run_max_next  = in_data;
      run_rise_next = '0;
    end else begin
      if (lt_min) run_min_next = in_data;
      if (gt_max) run_max_next = in_data;
      run_rise_next = run_rise_reg + {{(CNT_WIDTH-1){1'b0}}, gt_prev};
    end
  end

`ifdef WINDOW_INDEX_EN
  // Index of the most recent min/max update within the window.
  always_comb begin
    min_idx_next = min_idx_reg;
    max_idx_next = max_idx_reg;
    if (first) begin
      min_idx_next = '0;
      max_idx_next = '0;
    end else begin
      if (lt_min) min_idx_next = cnt_reg;
      if (gt_max) max_idx_next = cnt_reg;
    end
  end
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_reg <= ACCUM;
    else       state_reg <= state_next;
  end

  // Next-state: leave ACCUM on the last sample, leave HOLD when the result is taken.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ACCUM:   if (accept && last) state_next = HOLD;
      HOLD:    if (out_ready)      state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  // Handshake outputs decoded from state only.
  always_comb begin
    in_ready  = (state_reg == ACCUM);
    out_valid = (state_reg == HOLD);
  end

  // Running registers and sample counter; results latched at window end.
  always_ff @(posedge clock) begin
    if (reset) begin
      run_min_reg  <= '0;
      run_max_reg  <= '0;
      prev_reg     <= '0;
      run_rise_reg <= '0;
      cnt_reg      <= '0;
      min_out      <= '0;
      max_out      <= '0;
      rise_count   <= '0;
`ifdef WINDOW_INDEX_EN
      min_idx_reg  <= '0;
      max_idx_reg  <= '0;
      min_idx      <= '0;
      max_idx      <= '0;
`endif
    end else if (accept) begin
      run_min_reg  <= run_min_next;
      run_max_reg  <= run_max_next;
      prev_reg     <= in_data;
      run_rise_reg <= run_rise_next;
      cnt_reg      <= last ? '0 : cnt_reg + IDX_WIDTH'(1);
`ifdef WINDOW_INDEX_EN
      min_idx_reg  <= min_idx_next;
      max_idx_reg  <= max_idx_next;
`endif
      if (last) begin
        min_out    <= run_min_next;
        max_out    <= run_max_next;
        rise_count <= run_rise_next;
`ifdef WINDOW_INDEX_EN
        min_idx    <= min_idx_next;
        max_idx    <= max_idx_next;
`endif
      end
    end
  end

endmodule

// File: tb/tb_window_extrema_tracker.sv
// Testbench for window_extrema_tracker (WINDOW=4): directed scenarios plus
// random traffic, checked each cycle against a window-level reference model.
module tb_window_extrema_tracker;

  localparam int W  = 4;
  localparam int DW = 8;
  localparam int CW = $clog2(W + 1);
  localparam int IW = $clog2(W);

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] min_out, max_out;
  logic [CW-1:0] rise_count;
`ifdef WINDOW_INDEX_EN
  logic [IW-1:0] min_idx, max_idx;
`endif

  window_extrema_tracker #(.DATA_WIDTH(DW), .WINDOW(W)) dut (
    .clock(clock), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .min_out(min_out), .max_out(max_out),
`ifdef WINDOW_INDEX_EN
    .min_idx(min_idx), .max_idx(max_idx),
`endif
    .rise_count(rise_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // Reference model state.
  bit      m_hold;
  int      m_win[$];
  int      m_min, m_max, m_rise, m_min_idx, m_max_idx;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d Error!! t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Evaluate a completed window from the full list of its samples.
  task automatic finish_window();
    m_min = m_win[0]; m_max = m_win[0]; m_min_idx = 0; m_max_idx = 0; m_rise = 0;
    for (int i = 1; i < m_win.size(); i++) begin
      if (m_win[i] < m_min) begin m_min = m_win[i]; m_min_idx = i; end
      if (m_win[i] > m_max) begin m_max = m_win[i]; m_max_idx = i; end
      if (m_win[i] > m_win[i-1]) m_rise++;
    end
    m_win.delete();
    m_hold = 1'b1;
  endtask

  // One clock cycle: drive, advance model on the edge, check after it.
  task automatic cycle(input bit v, input int d, input bit ordy, input bit rst);
    reset = rst; in_valid = v; in_data = DW'(d); out_ready = ordy;
    @(posedge clock);
    if (rst) begin
      m_hold = 1'b0; m_win.delete();
      m_min = 0; m_max = 0; m_rise = 0; m_min_idx = 0; m_max_idx = 0;
    end else if (!m_hold && v) begin
      m_win.push_back(d);
      if (m_win.size() == W) finish_window();
    end else if (m_hold && ordy) begin
      m_hold = 1'b0;
    end
    #1;
    check_val("in_ready",   int'(in_ready),   int'(!m_hold));
    check_val("out_valid",  int'(out_valid),  int'(m_hold));
    check_val("min_out",    int'(min_out),    m_min);
    check_val("max_out",    int'(max_out),    m_max);
    check_val("rise_count", int'(rise_count), m_rise);
`ifdef WINDOW_INDEX_EN
    check_val("min_idx",    int'(min_idx),    m_min_idx);
    check_val("max_idx",    int'(max_idx),    m_max_idx);
`endif
  endtask

  task automatic feed4(input int a, input int b, input int c, input int e, input bit ordy);
    cycle(1, a, ordy, 0); cycle(1, b, ordy, 0); cycle(1, c, ordy, 0); cycle(1, e, ordy, 0);
  endtask

  initial begin
    // Reset state, with a sample offered during reset that must be ignored.
    cycle(1, 99, 1, 1);
    cycle(0, 0, 1, 1);
    check_val("rst_min", int'(min_out), 0);
    check_val("rst_ready", int'(in_ready), 1);

    // 10,12,9,3 back to back.
    feed4(10, 12, 9, 3, 1);
    check_val("t1_min", int'(min_out), 3);
    check_val("t1_max", int'(max_out), 12);
    check_val("t1_rise", int'(rise_count), 1);
    check_val("t1_valid", int'(out_valid), 1);
    cycle(0, 0, 1, 0);
    check_val("t1_valid_drop", int'(out_valid), 0);

    // All ties.
    feed4(7, 7, 7, 7, 1);
    check_val("t2_min", int'(min_out), 7);
    check_val("t2_rise", int'(rise_count), 0);
    cycle(0, 0, 1, 0);

    // Backpressure: 5 held cycles with a 5th sample offered throughout.
    feed4(0, 255, 0, 255, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 77, 0, 0);
      check_val("t3_hold", int'(out_valid), 1);
    end
    check_val("t3_max", int'(max_out), 255);
    check_val("t3_rise", int'(rise_count), 2);
    cycle(1, 77, 1, 0);   // take, 77 not accepted here
    cycle(1, 77, 1, 0);   // 77 accepted as first sample
    cycle(1, 80, 1, 0); cycle(1, 70, 1, 0); cycle(1, 90, 1, 0);
    check_val("t3_next_min", int'(min_out), 70);
    cycle(0, 0, 1, 0);

    // Bubbles interleaved.
    for (int i = 1; i <= 4; i++) begin
      cycle(1, i, 1, 0);
      if (i < 4) cycle(0, 200, 1, 0);
    end
    check_val("t4_min", int'(min_out), 1);
    check_val("t4_max", int'(max_out), 4);
    check_val("t4_rise", int'(rise_count), 3);
    cycle(0, 0, 1, 0);

    // Reset discards a partial window.
    cycle(1, 50, 1, 0); cycle(1, 60, 1, 0);
    cycle(0, 0, 1, 1);
    feed4(21, 42, 1, 2, 1);
    check_val("t5_min", int'(min_out), 1);
    check_val("t5_max", int'(max_out), 42);
    check_val("t5_rise", int'(rise_count), 2);
    cycle(0, 0, 1, 0);

    // Random traffic, narrow value range half the time to provoke ties.
    for (int n = 0; n < 600; n++) begin
      int d;
      d = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 255));
      cycle(($urandom_range(0, 3) != 0), d, ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 79) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
